pulse_seq: RTL and testbench
============================

# pulse_seq

Parametrised multi-echo pulse sequencer: the successor to the single Hahn/CPMG pulse generator. Drives the pulse switch, the blocking switch and the scope trigger from the PLL clock. It supports 0 to 2^NPI_W−1 refocusing (pi) pulses per period, with a re-closing echo window around every intermediate echo. Configuration is captured into shadow registers only at period start, so software can update it mid-period without glitching the running sequence.

## Interface
- CNT_W, 32, width of period counter and `per`
- WID_W, 16, width of `p1wid`, `del`, `p2wid`
- NPI_W, 8, width of `npi` / `pi_idx`
- clk_pll  in  1  PLL clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- per  in  CNT_W  period length minus one (period = per+1 cycles)
- p1wid  in  WID_W  first (pi/2) pulse width, cycles
- del  in  WID_W  tau: delay from end of p1 to start of first pi
- p2wid  in  WID_W  pi pulse width, cycles
- npi  in  NPI_W  number of pi pulses; 0 selects CW mode
- bl  in  1  blocking enable
- pulse_block  in  8  echo half-window, cycles
- sync_on  out  1  scope trigger
- pulse_on  out  1  pulse switch
- inhib  out  1  blocking switch (1 = blocked)
- pi_idx  out  NPI_W  index of current or last pi pulse (1-based, 0 before first)
- overrun  out  1  sticky: sequence truncated by period end

## Operation
- Free-running counter t = 0..per, wraps to 0. At t=0 all inputs are latched into shadow registers. Input changes at any other t take effect next period.
- CW mode (npi=0): pulse_on=1, inhib=0, sync_on=1 for t < (per>>1), else 0. pi_idx=0.
- Pulsed FSM states: P1 → DLY → PI → (ECHO → PI)* → TAIL.
  - P1: p1wid cycles, pulse_on=1.
  - DLY: del cycles, pulse_on=0.
  - PI: p2wid cycles, pulse_on=1; pi_idx increments on entry.
  - ECHO: 2·del cycles, pulse_on=0; entered after PI if pi_idx < npi, else TAIL.
  - TAIL: pulse_on=0 until wrap.
- Zero-length states are skipped in 0 cycles. Example: p1wid=0 means pulse_on never rises for p1.
- sync_on=1 from t=0 until the end of the last PI.
- inhib=bl at t=0. Let s be the cycle a PI ends. Let o = max(del − pulse_block, 0), computed saturating with no wrap.
  - Intermediate echo: inhib=0 for s+o ≤ t < s+del+pulse_block, then inhib=bl again.
  - Final echo: inhib=0 from s+o until wrap.
- Internal arithmetic is at least WID_W+1 bits wide (2·del cannot overflow).
- If t reaches per before TAIL, the sequence is aborted: wrap proceeds normally, overrun is set, and the FSM restarts at P1.
- In this spec, "cycle t" means the internal counter value. Outputs are registered and change one clk_pll cycle after the counter value that causes them. All timings below are stated relative to the output edge that starts t=0.

## Timing
- Reset (reset_n=0, asynchronous): counter=0, FSM=P1, sync_on=0, pulse_on=0, inhib=0, pi_idx=0, overrun=0. Shadow registers are cleared to 0.
- First output edge occurs one cycle after reset_n deasserts. The first period uses inputs sampled on that cycle.
- Period is exactly per+1 cycles. per=0 gives a 1-cycle period: every cycle is t=0.
- overrun is cleared only by reset.
- Reset asserted mid-sequence: outputs drop to reset values immediately, with no completion of the current pulse.
- A state transition coinciding with wrap resolves as wrap (restart at P1).

## Configuration
- PULSE_SEQ_PHASE_EN defined: adds output `phase` (1 bit, reset 0).
  - phase=0 during P1.
  - phase toggles on entry to each PI (pi 1 → 1, pi 2 → 0, …), for XY-alternated refocusing.
  - phase holds its value outside PI states and returns to 0 at wrap.
- PULSE_SEQ_PHASE_EN undefined: `phase` port and its logic are absent. All other behaviour is identical.

## Test plan
- CW: per=99, npi=0 → pulse_on=1, inhib=0 constant; sync_on high t 0–48, low t 49–99, repeating every 100 cycles.
- Two-pi CPMG: per=999, p1wid=10, del=50, p2wid=20, npi=2, bl=1, pulse_block=5 → pulse_on high t 0–9, 60–79, 180–199; sync_on high t 0–199; inhib low t 125–134 and 245–999, high elsewhere; pi_idx=2 from t=180.
- Overrun: same config with per=99 → wrap at t=99 during ECHO, FSM restarts at P1, overrun=1 and stays 1.
- Shadow load: change del 50→30 at t=500 of a period → current period unchanged; next period second pi starts at t=10+30+20+60=120.
- Saturation/zero width: p1wid=0, del=3, pulse_block=10, npi=1, bl=1 → pulse_on never high before DLY; inhib drops at first PI end and stays low to wrap.
- Async reset at t=70 (mid-PI) → all outputs 0 with no clock edge; after release, sequence restarts at t=0.

Source files
------------

// File: rtl/pulse_seq_if.sv
// Bundle of configuration inputs and pulse/status outputs for pulse_seq.
// Optional `phase` output is present only when PULSE_SEQ_PHASE_EN is defined.
interface pulse_seq_if #(
  parameter int CNT_W = 32,
  parameter int WID_W = 16,
  parameter int NPI_W = 8
);
  // No valid/ready: config is a level bus sampled only at t=0 of each period;
  // outputs are registered levels, valid every cycle after reset release.
  logic [CNT_W-1:0] per;
  logic [WID_W-1:0] p1wid;
  logic [WID_W-1:0] del;
  logic [WID_W-1:0] p2wid;
  logic [NPI_W-1:0] npi;
  logic             bl;
  logic [7:0]       pulse_block;
  logic             sync_on;
  logic             pulse_on;
  logic             inhib;
  logic [NPI_W-1:0] pi_idx;
  logic             overrun;
  logic [2:0]       fsm_state;
`ifdef PULSE_SEQ_PHASE_EN
  logic             phase;
`endif

  modport master (
    output per, p1wid, del, p2wid, npi, bl, pulse_block,
    input  sync_on, pulse_on, inhib, pi_idx, overrun, fsm_state
`ifdef PULSE_SEQ_PHASE_EN
    , input phase
`endif
  );

  modport slave (
    input  per, p1wid, del, p2wid, npi, bl, pulse_block,
    output sync_on, pulse_on, inhib, pi_idx, overrun, fsm_state
`ifdef PULSE_SEQ_PHASE_EN
    , output phase
`endif
  );
endinterface

// File: rtl/pulse_seq.sv
// Multi-echo pulse sequencer (P1 -> DLY -> PI -> (ECHO -> PI)* -> TAIL) with echo blanking.
// Define PULSE_SEQ_PHASE_EN to add the XY-alternation `phase` output.
module pulse_seq #(
  parameter int CNT_W = 32,
  parameter int WID_W = 16,
  parameter int NPI_W = 8
) (
  input  logic       clk_pll,
  input  logic       reset_n,
  pulse_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_P1   = 3'd0,
    S_DLY  = 3'd1,
    S_PI   = 3'd2,
    S_ECHO = 3'd3,
    S_TAIL = 3'd4
  } state_t;

  localparam int LW = WID_W + 1;
  localparam int EW = WID_W + 2;
  localparam logic [CNT_W-1:0] T_ONE  = CNT_W'(1);
  localparam logic [LW-1:0]    C_ONE  = LW'(1);
  localparam logic [EW-1:0]    E_ONE  = EW'(1);
  localparam logic [NPI_W-1:0] PI_ONE = NPI_W'(1);

  logic [CNT_W-1:0] t_q, t_d, per_q, per_e;
  logic [WID_W-1:0] p1wid_q, del_q, p2wid_q, p1wid_e, del_e, p2wid_e;
  logic [NPI_W-1:0] npi_q, npi_e;
  logic [7:0]       pb_q, pb_e;
  logic             bl_q, bl_e;

  state_t           st_q, st_d, cur;
  logic [LW-1:0]    cnt_q, cnt_d, c;
  logic [NPI_W-1:0] pi_q, pi_d, pi;
  logic             win_act_q, win_act_d, win_fin_q, win_fin_d;
  logic [EW-1:0]    win_cnt_q, win_cnt_d, e, o_len, win_end, del_x, pb_x;
  logic             first, wrap, cw, pi_end, last, act, fin, open_w;

  logic             sync_q, pulse_q, inhib_q, overrun_q;
  logic             sync_d, pulse_d, inhib_d, overrun_d;
  logic [NPI_W-1:0] pi_idx_q, pi_idx_d;

  // At t=0 the live inputs drive this cycle directly while being captured.
  always_comb begin
    first   = (t_q == '0);
    per_e   = first ? bus.per         : per_q;
    p1wid_e = first ? bus.p1wid       : p1wid_q;
    del_e   = first ? bus.del         : del_q;
    p2wid_e = first ? bus.p2wid       : p2wid_q;
    npi_e   = first ? bus.npi         : npi_q;
    bl_e    = first ? bus.bl          : bl_q;
    pb_e    = first ? bus.pulse_block : pb_q;
    cw      = (npi_e == '0);
    del_x   = {2'b00, del_e};
    pb_x    = {{(EW-8){1'b0}}, pb_e};
    o_len   = (del_x > pb_x) ? (del_x - pb_x) : '0;
    win_end = del_x + pb_x;
  end

  // Resolve the state for this cycle, skipping zero-length states in place.
  always_comb begin
    cur    = st_q;
    c      = cnt_q;
    pi     = pi_q;
    pi_end = 1'b0;
    last   = 1'b0;
    if (cur == S_P1 && c >= {1'b0, p1wid_e}) begin
      cur = S_DLY;
      c   = '0;
    end
    if (cur == S_DLY && c >= {1'b0, del_e}) begin
      cur = S_PI;
      c   = '0;
      pi  = pi + PI_ONE;
    end
    if (cur == S_PI && c >= {1'b0, p2wid_e}) begin
      pi_end = 1'b1;
      last   = (pi >= npi_e);
      cur    = last ? S_TAIL : S_ECHO;
      c      = '0;
    end
    if (cur == S_ECHO && c >= {del_e, 1'b0}) begin
      cur = S_PI;
      c   = '0;
      pi  = pi + PI_ONE;
    end
    if (cur == S_PI && c >= {1'b0, p2wid_e}) begin
      pi_end = 1'b1;
      last   = (pi >= npi_e);
      cur    = last ? S_TAIL : S_ECHO;
      c      = '0;
    end
  end

  // Echo window: e counts cycles since the most recent PI ended.
  always_comb begin
    e      = pi_end ? '0 : win_cnt_q;
    act    = pi_end | win_act_q;
    fin    = pi_end ? last : win_fin_q;
    open_w = act && (e >= o_len) && (fin || (e < win_end));
  end

  always_comb begin
    wrap      = (t_q >= per_e);
    t_d       = wrap ? '0 : t_q + T_ONE;
    st_d      = cur;
    cnt_d     = (cur == S_TAIL) ? c : c + C_ONE;
    pi_d      = pi;
    win_act_d = act;
    win_fin_d = fin;
    win_cnt_d = (act && e != '1) ? e + E_ONE : e;
    if (wrap) begin
      st_d      = S_P1;
      cnt_d     = '0;
      pi_d      = '0;
      win_act_d = 1'b0;
      win_fin_d = 1'b0;
      win_cnt_d = '0;
    end
  end

  always_comb begin
    sync_d    = 1'b0;
    pulse_d   = 1'b0;
    inhib_d   = 1'b0;
    pi_idx_d  = '0;
    overrun_d = overrun_q | (wrap & ~cw & (cur != S_TAIL));
    if (cw) begin
      pulse_d = 1'b1;
      sync_d  = (t_q < (per_e >> 1));
    end else begin
      pulse_d  = (cur == S_P1) || (cur == S_PI);
      sync_d   = (cur != S_TAIL);
      inhib_d  = bl_e & ~open_w;
      pi_idx_d = pi;
    end
  end

  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) begin
      t_q       <= '0;
      per_q     <= '0;
      p1wid_q   <= '0;
      del_q     <= '0;
      p2wid_q   <= '0;
      npi_q     <= '0;
      bl_q      <= 1'b0;
      pb_q      <= '0;
      st_q      <= S_P1;
      cnt_q     <= '0;
      pi_q      <= '0;
      win_act_q <= 1'b0;
      win_fin_q <= 1'b0;
      win_cnt_q <= '0;
      sync_q    <= 1'b0;
      pulse_q   <= 1'b0;
      inhib_q   <= 1'b0;
      pi_idx_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      t_q <= t_d;
      if (first) begin
        per_q   <= bus.per;
        p1wid_q <= bus.p1wid;
        del_q   <= bus.del;
        p2wid_q <= bus.p2wid;
        npi_q   <= bus.npi;
        bl_q    <= bus.bl;
        pb_q    <= bus.pulse_block;
      end
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      pi_q      <= pi_d;
      win_act_q <= win_act_d;
      win_fin_q <= win_fin_d;
      win_cnt_q <= win_cnt_d;
      sync_q    <= sync_d;
      pulse_q   <= pulse_d;
      inhib_q   <= inhib_d;
      pi_idx_q  <= pi_idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.sync_on   = sync_q;
  assign bus.pulse_on  = pulse_q;
  assign bus.inhib     = inhib_q;
  assign bus.pi_idx    = pi_idx_q;
  assign bus.overrun   = overrun_q;
  assign bus.fsm_state = st_q;

`ifdef PULSE_SEQ_PHASE_EN
  // Odd-numbered pi pulses are phase 1; pi_idx is 0 during P1 and after wrap.
  logic phase_q;
  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) phase_q <= 1'b0;
    else          phase_q <= pi_idx_d[0];
  end
  assign bus.phase = phase_q;
`endif
endmodule

// File: tb/tb_pulse_seq.sv
// Directed bench for pulse_seq: range tables of expected outputs per scenario
// plus hand sequences for mid-period reconfiguration and asynchronous reset.
module tb_pulse_seq;
`ifdef PULSE_SEQ_PHASE_EN
  localparam int W = 13;
`else
  localparam int W = 12;
`endif

  typedef struct {
    int         scen;
    int         lo;
    int         hi;
    logic       s;
    logic       p;
    logic       i;
    logic       ov;
    logic [7:0] pi;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  vec_t tbl[$];
  logic [W-1:0] exp_q[$];

  pulse_seq_if #(.CNT_W(32), .WID_W(16), .NPI_W(8)) bus ();

  pulse_seq #(.CNT_W(32), .WID_W(16), .NPI_W(8)) dut (
    .clk_pll (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] got_vec();
    logic [W-1:0] g;
`ifdef PULSE_SEQ_PHASE_EN
    g = {bus.sync_on, bus.pulse_on, bus.inhib, bus.overrun, bus.pi_idx, bus.phase};
`else
    g = {bus.sync_on, bus.pulse_on, bus.inhib, bus.overrun, bus.pi_idx};
`endif
    return g;
  endfunction

  function automatic logic [W-1:0] exp_vec(input vec_t v);
    logic [W-1:0] x;
`ifdef PULSE_SEQ_PHASE_EN
    x = {v.s, v.p, v.i, v.ov, v.pi, v.pi[0]};
`else
    x = {v.s, v.p, v.i, v.ov, v.pi};
`endif
    return x;
  endfunction

  function automatic void add(input int scen, input int lo, input int hi, input logic s,
                              input logic p, input logic i, input logic ov, input int pi);
    vec_t v;
    v.scen = scen; v.lo = lo; v.hi = hi;
    v.s = s; v.p = p; v.i = i; v.ov = ov; v.pi = pi[7:0];
    tbl.push_back(v);
  endfunction

  // Scoreboard: drain expectations queued for this sample against the DUT.
  task automatic score(input string name, input int scen, input int k);
    logic [W-1:0] x;
    logic [W-1:0] g;
    g = got_vec();
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_tests++;
      if (g !== x) begin
        n_fail++;
        $display("FAIL %s scen=%0d t=%0d got={s,p,i,ov,pi..}=%h expected=%h", name, scen, k, g, x);
      end
    end
  endtask

  // Driver tasks
  task automatic set_cfg(input int per, input int p1, input int d, input int p2,
                         input int n, input logic b, input int pb);
    bus.per         = per;
    bus.p1wid       = p1[15:0];
    bus.del         = d[15:0];
    bus.p2wid       = p2[15:0];
    bus.npi         = n[7:0];
    bus.bl          = b;
    bus.pulse_block = pb[7:0];
  endtask

  task automatic do_reset(input int scen);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    score("reset_state", scen, -1);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run(input int scen, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      foreach (tbl[j]) begin
        if (tbl[j].scen == scen && k >= tbl[j].lo && k <= tbl[j].hi)
          exp_q.push_back(exp_vec(tbl[j]));
      end
      score("cycle", scen, k);
      if (scen == 3 && k == 500)  bus.del = 16'd30;
      if (scen == 3 && k == 1100) bus.del = 16'd50;
    end
  endtask

  task automatic add_cpmg_period(input int scen, input int b);
    add(scen, b+0,   b+9,   1, 1, 1, 0, 0);
    add(scen, b+10,  b+59,  1, 0, 1, 0, 0);
    add(scen, b+60,  b+79,  1, 1, 1, 0, 1);
    add(scen, b+80,  b+124, 1, 0, 1, 0, 1);
    add(scen, b+125, b+134, 1, 0, 0, 0, 1);
    add(scen, b+135, b+179, 1, 0, 1, 0, 1);
    add(scen, b+180, b+199, 1, 1, 1, 0, 2);
    add(scen, b+200, b+244, 0, 0, 1, 0, 2);
    add(scen, b+245, b+999, 0, 0, 0, 0, 2);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    set_cfg(99, 10, 50, 20, 0, 1'b1, 5);

    // 0: CW mode, bl=1 must not block
    add(0, 0,   48,  1, 1, 0, 0, 0);
    add(0, 49,  99,  0, 1, 0, 0, 0);
    add(0, 100, 148, 1, 1, 0, 0, 0);
    add(0, 149, 199, 0, 1, 0, 0, 0);
    // 1: two-pi CPMG, then start of next period
    add_cpmg_period(1, 0);
    add(1, 1000, 1009, 1, 1, 1, 0, 0);
    // 2: overrun with per=99, wrap during ECHO
    add(2, 0,   9,   1, 1, 1, 0, 0);
    add(2, 10,  59,  1, 0, 1, 0, 0);
    add(2, 60,  79,  1, 1, 1, 0, 1);
    add(2, 80,  98,  1, 0, 1, 0, 1);
    add(2, 99,  99,  1, 0, 1, 1, 1);
    add(2, 100, 109, 1, 1, 1, 1, 0);
    add(2, 110, 159, 1, 0, 1, 1, 0);
    add(2, 160, 169, 1, 1, 1, 1, 1);
    // 3: shadow load; del=30 applied from second period only
    add_cpmg_period(3, 0);
    add(3, 1000, 1009, 1, 1, 1, 0, 0);
    add(3, 1010, 1039, 1, 0, 1, 0, 0);
    add(3, 1040, 1059, 1, 1, 1, 0, 1);
    add(3, 1060, 1084, 1, 0, 1, 0, 1);
    add(3, 1085, 1094, 1, 0, 0, 0, 1);
    add(3, 1095, 1119, 1, 0, 1, 0, 1);
    add(3, 1120, 1139, 1, 1, 1, 0, 2);
    add(3, 1140, 1164, 0, 0, 1, 0, 2);
    add(3, 1165, 1999, 0, 0, 0, 0, 2);
    add(3, 2000, 2009, 1, 1, 1, 0, 0);
    add(3, 2010, 2059, 1, 0, 1, 0, 0);
    add(3, 2060, 2079, 1, 1, 1, 0, 1);
    // 4: p1wid=0 and saturated window offset
    add(4, 0,  2,  1, 0, 1, 0, 0);
    add(4, 3,  6,  1, 1, 1, 0, 1);
    add(4, 7,  49, 0, 0, 0, 0, 1);
    add(4, 50, 52, 1, 0, 1, 0, 0);
    add(4, 53, 56, 1, 1, 1, 0, 1);
    // 5: run into the first PI before an async reset
    add(5, 0,  9,  1, 1, 1, 0, 0);
    add(5, 10, 59, 1, 0, 1, 0, 0);
    add(5, 60, 70, 1, 1, 1, 0, 1);
    // 6: restart after the async reset
    add(6, 0,   9,   1, 1, 1, 0, 0);
    add(6, 10,  59,  1, 0, 1, 0, 0);
    add(6, 60,  79,  1, 1, 1, 0, 1);
    add(6, 80,  124, 1, 0, 1, 0, 1);
    add(6, 125, 134, 1, 0, 0, 0, 1);
    add(6, 135, 139, 1, 0, 1, 0, 1);

    set_cfg(99, 10, 50, 20, 0, 1'b1, 5);
    do_reset(0);
    run(0, 200);

    set_cfg(999, 10, 50, 20, 2, 1'b1, 5);
    do_reset(1);
    run(1, 1010);

    set_cfg(99, 10, 50, 20, 2, 1'b1, 5);
    do_reset(2);
    run(2, 170);

    set_cfg(999, 10, 50, 20, 2, 1'b1, 5);
    do_reset(3);
    run(3, 2080);

    set_cfg(49, 0, 3, 4, 1, 1'b1, 10);
    do_reset(4);
    run(4, 57);

    set_cfg(999, 10, 50, 20, 2, 1'b1, 5);
    do_reset(5);
    run(5, 71);
    // Mid-PI async reset between clock edges: outputs must clear at once.
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back('0);
    score("async_reset", 5, 70);
    do_reset(6);
    run(6, 140);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
